// File: rtl/bit_pack_stage.sv
// Serial-to-parallel packer: collects W qualified bits LSB-first into a word
// and queues completed words in a 2-deep output FIFO with a sticky overflow flag.
module bit_pack_stage #(
   parameter int W = 8
) (
   input  logic               clock_10,
   input  logic               clock_12,
   input  logic               in18,
   input  logic               in_en,
   input  logic               in_clr,
   input  logic               out_ready,
   output logic [W-1:0]       out_word,
   output logic               out_valid,
   output logic [$clog2(W):0] out_cnt,
   output logic               out_ovf
);

   localparam int CW = $clog2(W) + 1;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} fifo_state_t;

   fifo_state_t state, state_next;

   logic [W-2:0]  partial;
   logic [W-1:0]  extended;
   logic [W-1:0]  new_word;
   logic [W-1:0]  tail;
   logic [W-1:0]  head_next;
   logic [W-1:0]  tail_next;
   logic          accept;
   logic          complete;
   logic          pop;
   logic          drop;

   // Bits enter at the top and walk down, so after W-1 accepts the first bit sits in bit 0.
   assign extended = {in18, partial};
   assign new_word = {in18, partial};
   assign accept   = in_en && !in_clr;
   assign complete = accept && (out_cnt == CW'(W - 1));
   assign pop      = (state != EMPTY) && out_ready;

   always_ff @(posedge clock_10 or posedge clock_12) begin
      if (clock_12) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // The FIFO head is the out_word register itself; pops happen before pushes on a shared edge.
   always_comb begin
      state_next = state;
      head_next  = out_word;
      tail_next  = tail;
      drop       = 1'b0;
      unique case (state)
         EMPTY: begin
            if (complete) begin
               state_next = ONE;
               head_next  = new_word;
            end
         end
         ONE: begin
            if (complete && !pop) begin
               state_next = TWO;
               tail_next  = new_word;
            end else if (complete && pop) begin
               head_next = new_word;
            end else if (pop) begin
               state_next = EMPTY;
               head_next  = '0;
            end
         end
         TWO: begin
            if (pop) begin
               head_next = tail;
               if (complete) begin
                  tail_next = new_word;
               end else begin
                  state_next = ONE;
                  tail_next  = '0;
               end
            end else if (complete) begin
               drop = 1'b1;
            end
         end
         default: begin
            state_next = EMPTY;
            head_next  = '0;
            tail_next  = '0;
         end
      endcase
   end

   always_ff @(posedge clock_10 or posedge clock_12) begin
      if (clock_12) begin
         out_word  <= '0;
         tail      <= '0;
         out_valid <= 1'b0;
         out_ovf   <= 1'b0;
      end else begin
         out_word  <= head_next;
         tail      <= tail_next;
         out_valid <= (state_next != EMPTY);
         if (drop) begin
            out_ovf <= 1'b1;
         end
      end
   end

   // A clear wins over an accept, and the counter wraps even when the word is dropped.
   always_ff @(posedge clock_10 or posedge clock_12) begin
      if (clock_12) begin
         out_cnt <= '0;
         partial <= '0;
      end else if (in_clr) begin
         out_cnt <= '0;
         partial <= '0;
      end else if (accept) begin
         if (complete) begin
            out_cnt <= '0;
            partial <= '0;
         end else begin
            out_cnt <= out_cnt + CW'(1);
            partial <= extended[W-1:1];
         end
      end
   end

endmodule

// File: tb/tb_bit_pack_stage.sv
// Self-checking bench for bit_pack_stage: directed scenarios plus a randomized
// run, all compared against a queue-based reference model.
module tb_bit_pack_stage;

   localparam int W = 8;

   logic               clock_10 = 1'b0;
   logic               clock_12;
   logic               in18;
   logic               in_en;
   logic               in_clr;
   logic               out_ready;
   logic [W-1:0]       out_word;
   logic               out_valid;
   logic [$clog2(W):0] out_cnt;
   logic               out_ovf;

   int n_asserts = 0;
   int n_fail    = 0;

   // Reference model: bit count, partial word, queue of pending words, sticky flag.
   int           m_cnt;
   logic [W-1:0] m_part;
   logic [W-1:0] m_q[$];
   logic         m_ovf;

   bit_pack_stage #(.W(W)) dut (
      .clock_10 (clock_10),
      .clock_12 (clock_12),
      .in18     (in18),
      .in_en    (in_en),
      .in_clr   (in_clr),
      .out_ready(out_ready),
      .out_word (out_word),
      .out_valid(out_valid),
      .out_cnt  (out_cnt),
      .out_ovf  (out_ovf)
   );

   always #5 clock_10 = ~clock_10;

   task automatic modelReset();
      m_cnt  = 0;
      m_part = '0;
      m_q.delete();
      m_ovf  = 1'b0;
   endtask

   task automatic modelEdge(input bit en, input bit b, input bit clr, input bit rdy);
      bit           do_pop;
      bit           done;
      logic [W-1:0] w;
      logic [W-1:0] gone;
      do_pop = (m_q.size() > 0) && rdy;
      done   = 1'b0;
      w      = '0;
      if (clr) begin
         m_cnt  = 0;
         m_part = '0;
      end else if (en) begin
         m_part[m_cnt] = b;
         m_cnt++;
         if (m_cnt == W) begin
            done   = 1'b1;
            w      = m_part;
            m_cnt  = 0;
            m_part = '0;
         end
      end
      if (do_pop) gone = m_q.pop_front();
      if (done) begin
         if (m_q.size() == 2) m_ovf = 1'b1;
         else m_q.push_back(w);
      end
   endtask

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [W-1:0] exp_word;
      exp_word = (m_q.size() > 0) ? m_q[0] : '0;
      checkValue({tag, ".word"},  32'(out_word),  32'(exp_word));
      checkValue({tag, ".valid"}, 32'(out_valid), 32'(m_q.size() > 0));
      checkValue({tag, ".cnt"},   32'(out_cnt),   32'(m_cnt));
      checkValue({tag, ".ovf"},   32'(out_ovf),   32'(m_ovf));
   endtask

   task automatic applyStimulus(input bit en, input bit b, input bit clr, input bit rdy);
      in_en     = en;
      in18      = b;
      in_clr    = clr;
      out_ready = rdy;
      @(posedge clock_10);
      modelEdge(en, b, clr, rdy);
      #1;
   endtask

   task automatic step(input bit en, input bit b, input bit clr, input bit rdy, input string tag);
      applyStimulus(en, b, clr, rdy);
      checkOutput(tag);
   endtask

   // Feeds a whole word; the completing bit may use a different ready than the rest.
   task automatic sendWord(input logic [W-1:0] w, input bit rdy, input bit rdy_last, input string tag);
      for (int i = 0; i < W; i++) begin
         step(1'b1, w[i], 1'b0, (i == W - 1) ? rdy_last : rdy, tag);
      end
   endtask

   task automatic doReset(input string tag);
      clock_12 = 1'b1;
      #2;
      modelReset();
      checkOutput(tag);
      clock_12 = 1'b0;
   endtask

   initial begin
      clock_12  = 1'b1;
      in18      = 1'b0;
      in_en     = 1'b0;
      in_clr    = 1'b0;
      out_ready = 1'b0;
      modelReset();
      #2;
      checkOutput("reset");
      @(negedge clock_10);
      clock_12 = 1'b0;

      // Single word with ready held high, starting on the first edge after reset.
      sendWord(8'h4D, 1'b1, 1'b1, "w4d");
      checkValue("w4d.lit_word",  32'(out_word),  32'h4D);
      checkValue("w4d.lit_valid", 32'(out_valid), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, "w4d_after");
      checkValue("w4d.lit_gone", 32'(out_valid), 32'd0);

      // Three words into a stalled FIFO: the third is dropped.
      sendWord(8'h01, 1'b0, 1'b0, "ovf_a");
      sendWord(8'h02, 1'b0, 1'b0, "ovf_b");
      sendWord(8'h03, 1'b0, 1'b0, "ovf_c");
      checkValue("ovf.lit_word", 32'(out_word), 32'h01);
      checkValue("ovf.lit_flag", 32'(out_ovf),  32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, "ovf_drain1");
      checkValue("ovf.lit_second", 32'(out_word), 32'h02);
      step(1'b0, 1'b0, 1'b0, 1'b1, "ovf_drain2");
      checkValue("ovf.lit_empty",  32'(out_valid), 32'd0);
      checkValue("ovf.lit_sticky", 32'(out_ovf),   32'd1);

      // Completing a word while full, on the same edge as a pop.
      doReset("reset2");
      sendWord(8'h11, 1'b0, 1'b0, "full_a");
      sendWord(8'h22, 1'b0, 1'b0, "full_b");
      sendWord(8'h33, 1'b0, 1'b1, "full_c");
      checkValue("full.lit_noovf", 32'(out_ovf),  32'd0);
      checkValue("full.lit_head",  32'(out_word), 32'h22);
      step(1'b0, 1'b0, 1'b0, 1'b1, "full_drain1");
      checkValue("full.lit_tail", 32'(out_word), 32'h33);
      step(1'b0, 1'b0, 1'b0, 1'b1, "full_drain2");
      checkValue("full.lit_empty", 32'(out_valid), 32'd0);

      // Clear beats a simultaneous accept.
      for (int i = 0; i < 5; i++) step(1'b1, 1'(i % 2), 1'b0, 1'b1, "clr_pre");
      checkValue("clr.lit_cnt5", 32'(out_cnt), 32'd5);
      step(1'b1, 1'b1, 1'b1, 1'b1, "clr_edge");
      checkValue("clr.lit_cnt0", 32'(out_cnt), 32'd0);
      sendWord(8'hFF, 1'b1, 1'b1, "clr_ff");
      checkValue("clr.lit_ff", 32'(out_word), 32'hFF);
      step(1'b0, 1'b0, 1'b0, 1'b1, "clr_after");

      // Asynchronous reset pulse between edges with a queued word and a partial word.
      sendWord(8'h5A, 1'b0, 1'b0, "ar_word");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "ar_bits");
      checkValue("ar.lit_cnt3", 32'(out_cnt), 32'd3);
      #3;
      clock_12 = 1'b1;
      #1;
      modelReset();
      checkOutput("ar_pulse");
      checkValue("ar.lit_valid0", 32'(out_valid), 32'd0);
      #1;
      clock_12 = 1'b0;
      sendWord(8'hC3, 1'b1, 1'b1, "ar_next");
      checkValue("ar.lit_c3", 32'(out_word), 32'hC3);
      step(1'b0, 1'b0, 1'b0, 1'b1, "ar_after");

      // Randomized traffic with scarce ready to provoke drops.
      doReset("reset3");
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), "rand");
      end
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, "rand_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/bit_pack_stage.md
BIT_PACK_STAGE -- requirements
Module: bit_pack_stage

Interface
REQ-001 SHALL have parameter W, default 8, meaning packed word width in bits (legal range 2..16).
REQ-002 SHALL have port clock_10, input, 1 bit, the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port clock_12, input, 1 bit, the reset, asynchronous and active-high.
REQ-004 SHALL have port in18, input, 1 bit, the serial data bit produced by the upstream flag stage.
REQ-005 SHALL have port in_en, input, 1 bit, which qualifies in18 as valid this cycle.
REQ-006 SHALL have port in_clr, input, 1 bit, a synchronous discard of the partial word.
REQ-007 SHALL have port out_ready, input, 1 bit, the downstream ready signal.
REQ-008 SHALL have port out_word, output, W bits, the head-of-FIFO packed word.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning out_word holds a valid word.
REQ-010 SHALL have port out_cnt, output, ceil(log2 W)+1 bits, giving the number of bits in the partial word.
REQ-011 SHALL have port out_ovf, output, 1 bit, a sticky flag meaning a word was dropped.

Function
REQ-012 SHALL accept in18 on each rising clock_10 where in_en=1 and in_clr=0, shifting it LSB-first into the partial word (first bit accepted lands in bit 0).
REQ-013 SHALL increment out_cnt by 1 per accepted bit, counting 0..W-1, and SHALL wrap to 0 on the edge that accepts bit W.
REQ-014 SHALL, on the edge accepting bit W, form the completed word from the W-1 stored bits plus the current in18 as bit W-1, and push it into a 2-entry FIFO.
REQ-015 SHALL register all outputs; a word pushed into an empty FIFO appears on out_word with out_valid=1 exactly one cycle after the completing edge.
REQ-016 SHALL pop the FIFO head on a rising edge where out_valid=1 and out_ready=1.
REQ-017 SHALL hold out_word stable while out_valid=1 and out_ready=0.
REQ-018 SHALL implement FIFO occupancy as an FSM with states EMPTY, ONE and TWO:
  - EMPTY: push -> ONE; otherwise stay.
  - ONE: push without pop -> TWO; pop without push -> EMPTY; push with pop -> ONE (new word becomes head); neither -> stay.
  - TWO: pop -> ONE, unless a push also occurs, in which case stay TWO with the new word in the tail.
REQ-019 SHALL, when a word completes in state TWO with no pop on that edge, discard the word, set out_ovf=1, and still wrap out_cnt to 0.
REQ-020 SHALL keep out_ovf at 1 until reset; in_clr SHALL NOT clear it.
REQ-021 SHALL, when in_clr=1, set out_cnt to 0 and the partial word to 0 on that edge, ignoring in_en/in18 that cycle, while leaving FIFO contents, FSM state and out_ovf unchanged.
REQ-022 SHALL drive out_valid=1 exactly when the FSM is in state ONE or TWO.
REQ-023 SHALL drive out_word=0 whenever out_valid=0.
REQ-024 SHALL ignore out_ready while out_valid=0 (no underflow; state remains EMPTY).

Reset
REQ-025 SHALL, while clock_12=1, immediately and independently of clock_10 force out_word=0, out_valid=0, out_cnt=0 and out_ovf=0, with the FSM in EMPTY and the partial word 0.
REQ-026 SHALL discard any partial word and all FIFO contents when reset asserts mid-operation.
REQ-027 SHALL accept the first bit on the first rising clock_10 after clock_12 deasserts.

Verification
REQ-028 SHALL be verified with W=8 and out_ready=1: serial bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles -> out_word=8'h4D with out_valid=1 for exactly 1 cycle, one cycle after the 8th edge.
REQ-029 SHALL be verified with out_ready=0: three full words 8'h01, 8'h02, 8'h03 -> out_valid=1, out_word=8'h01, out_ovf=1; then out_ready=1 -> outputs 8'h01 then 8'h02, followed by out_valid=0.
REQ-030 SHALL be verified with FIFO in TWO and the completing edge coinciding with out_ready=1: no overflow, and the words appear in order with none lost.
REQ-031 SHALL be verified with 5 bits accepted then in_clr=1 together with in_en=1: out_cnt=0, the bit is not captured, and the next 8 bits 8'hFF produce 8'hFF.
REQ-032 SHALL be verified with clock_12 pulsed between clock edges after 3 bits and one queued word: outputs are zero immediately, and the next word packs from bit 0.
REQ-033 SHALL be verified by a randomized in_en/out_ready run against a reference queue model: words match in order, and out_ovf rises exactly on the first drop.
